dice_roll_sequencer: RTL and testbench

//  Controls the two-digit BCD dice counter. Debounces the six die buttons and arbitrates between them.

---
 rtl/dice_pkg.sv | 43 ++++
 rtl/dice_roll_sequencer_if.sv | 37 +++
 rtl/btn_debounce.sv | 59 +++++
 rtl/dice_roll_sequencer.sv | 234 +++++++++++++++++++++++
 tb/tb_dice_roll_sequencer.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/dice_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dice_pkg
//  Purpose  : Shared definitions for the dice roll sequencer: die codes,
//             FSM state encodings, button count and the button priority
//             encoder.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package dice_pkg;

    localparam int NUM_BTN = 6;

    // Die codes, matching the button index order on the front panel
    typedef enum logic [2:0] {
        DIE_D4   = 3'd0,
        DIE_D6   = 3'd1,
        DIE_D8   = 3'd2,
        DIE_D10  = 3'd3,
        DIE_D20  = 3'd4,
        DIE_D100 = 3'd5
    } die_e;

    // Roll sequencer states
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SPIN  = 2'd1;
    localparam logic [1:0] ST_DECEL = 2'd2;
    localparam logic [1:0] ST_SHOW  = 2'd3;

    // Fixed-priority encoder: the lowest set index wins (d4 highest priority).
    function automatic die_e first_set(input logic [NUM_BTN-1:0] v);
        die_e sel;
        sel = DIE_D4;
        for (int i = NUM_BTN - 1; i >= 0; i--) begin
            if (v[i]) begin
                sel = die_e'(3'(i));
            end
        end
        return sel;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dice_roll_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : dice_roll_sequencer_if
//  Purpose  : Bundles the button inputs and the counter-control outputs of
//             the dice roll sequencer.
//  Signals  : btn_raw[5:0]  raw (synchronised) buttons d4..d100
//             die_sel[2:0]  latched die code
//             load, step    counter strobes
//             busy          roll in progress
//             result_valid  counter holds a finished roll
//             state_dbg[2:0] FSM state code
//  Modports : master - button source / counter side
//             slave  - the sequencer
//  Revision : 1.0 - initial release
// ============================================================================
interface dice_roll_sequencer_if;

    logic [dice_pkg::NUM_BTN-1:0] btn_raw;
    logic [2:0]                   die_sel;
    logic                         load;
    logic                         step;
    logic                         busy;
    logic                         result_valid;
    logic [2:0]                   state_dbg;

    modport master (
        output btn_raw,
        input  die_sel, load, step, busy, result_valid, state_dbg
    );

    modport slave (
        input  btn_raw,
        output die_sel, load, step, busy, result_valid, state_dbg
    );

endinterface
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
//  Module   : btn_debounce
//  Purpose  : Single-button debouncer. The debounced level follows the raw
//             input only after the two have disagreed for DEB_CYCLES
//             consecutive cycles; any agreeing cycle restarts the count.
//  Ports    : clk   in  system clock
//             rst   in  synchronous active-high reset
//             raw   in  synchronised raw button
//             level out debounced level (registered)
//             rise  out 1-cycle pulse, aligned with level going 0->1
//  Revision : 1.0 - initial release
// ============================================================================
module btn_debounce #(
    parameter int DEB_CYCLES = 328
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic rise
);

    localparam int             c_cw   = $clog2(DEB_CYCLES + 1);
    localparam logic [c_cw-1:0] c_last = c_cw'(DEB_CYCLES - 1);

    if (DEB_CYCLES < 1) begin : g_bad_deb
        $error("btn_debounce: DEB_CYCLES must be >= 1");
    end

    logic [c_cw-1:0] r_cnt;
    logic            r_level;
    logic            r_rise;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
        end else begin
            r_rise <= 1'b0;
            if (raw == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == c_last) begin
                // This is the DEB_CYCLES-th disagreeing cycle: accept the level
                r_cnt   <= '0;
                r_level <= raw;
                r_rise  <= raw;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign level = r_level;
    assign rise  = r_rise;

endmodule
`default_nettype wire

// File: rtl/dice_roll_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : dice_roll_sequencer
//  Purpose  : Controls the two-digit BCD dice counter. Debounces six die
//             buttons, picks the highest-priority press and sequences each
//             roll as LOAD -> SPIN (while held) -> DECEL (slowing) -> SHOW,
//             driving the counter with load/step strobes.
//  Ports    : clk  in  system clock (32768 Hz)
//             rst  in  synchronous active-high reset
//             bus  dice_roll_sequencer_if.slave
//                  btn_raw in, die_sel/load/step/busy/result_valid/
//                  state_dbg out (all outputs registered)
//  Revision : 1.0 - initial release
// ============================================================================
module dice_roll_sequencer
    import dice_pkg::*;
#(
    parameter int DEB_CYCLES  = 328,
    parameter int DECEL_BASE  = 4,
    parameter int DECEL_INC   = 2,
    parameter int DECEL_STEPS = 8,
    parameter int SHOW_CYCLES = 65536
) (
    input  logic                   clk,
    input  logic                   rst,
    dice_roll_sequencer_if.slave   bus
);

    // Longest gap is the one before the last DECEL step
    localparam int c_gap_max = DECEL_BASE + (DECEL_STEPS - 1) * DECEL_INC;
    localparam int c_gw      = $clog2(c_gap_max + 1);
    localparam int c_cw      = $clog2(DECEL_STEPS + 1);
    localparam int c_sw      = $clog2(SHOW_CYCLES + 1);

    localparam logic [c_gw-1:0] c_gap_base = c_gw'(DECEL_BASE);
    localparam logic [c_gw-1:0] c_gap_inc  = c_gw'(DECEL_INC);
    localparam logic [c_gw-1:0] c_gap_one  = c_gw'(1);
    localparam logic [c_cw-1:0] c_cnt_init = c_cw'(DECEL_STEPS);
    localparam logic [c_cw-1:0] c_cnt_one  = c_cw'(1);
    localparam logic [c_sw-1:0] c_show_end = c_sw'(SHOW_CYCLES - 1);

    if (DECEL_BASE < 1) begin : g_bad_base
        $error("dice_roll_sequencer: DECEL_BASE must be >= 1");
    end
    if (DECEL_STEPS < 1) begin : g_bad_steps
        $error("dice_roll_sequencer: DECEL_STEPS must be >= 1");
    end
    if (SHOW_CYCLES < 1) begin : g_bad_show
        $error("dice_roll_sequencer: SHOW_CYCLES must be >= 1");
    end

    // ------------------------------------------------------------------
    // Debouncers
    // ------------------------------------------------------------------
    logic [NUM_BTN-1:0] w_level;
    logic [NUM_BTN-1:0] w_rise;

    for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_deb
        btn_debounce #(
            .DEB_CYCLES (DEB_CYCLES)
        ) u_deb (
            .clk   (clk),
            .rst   (rst),
            .raw   (bus.btn_raw[gi]),
            .level (w_level[gi]),
            .rise  (w_rise[gi])
        );
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [1:0]      r_state;
    die_e            r_die_sel;
    logic [c_gw-1:0] r_gap;      // cycles left until the next DECEL step, 1 = step now
    logic [c_gw-1:0] r_len;      // length of the gap currently being counted
    logic [c_cw-1:0] r_cnt;      // DECEL steps still to issue, including the pending one
    logic [c_sw-1:0] r_show;
    logic            r_load;
    logic            r_step;
    logic            r_busy;
    logic            r_rv;

    // Next-state / next-value wires
    logic [1:0]      w_state_nxt;
    die_e            w_sel_nxt;
    logic [c_gw-1:0] w_gap_nxt;
    logic [c_gw-1:0] w_len_nxt;
    logic [c_cw-1:0] w_cnt_nxt;
    logic [c_sw-1:0] w_show_nxt;
    logic            w_new_roll;
    logic            w_load_nxt;
    logic            w_step_nxt;
    logic            w_busy_nxt;
    logic            w_rv_nxt;

    logic            w_sel_level;
    logic            w_sel_rise;

    assign w_sel_level = w_level[r_die_sel];
    assign w_sel_rise  = w_rise[r_die_sel];

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state and counter logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_die_sel;
        w_gap_nxt   = r_gap;
        w_len_nxt   = r_len;
        w_cnt_nxt   = r_cnt;
        w_show_nxt  = r_show;
        w_new_roll  = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (|w_rise) begin
                    w_new_roll  = 1'b1;
                    w_sel_nxt   = first_set(w_rise);
                    w_state_nxt = ST_SPIN;
                end
            end
            ST_SPIN: begin
                if (!w_sel_level) begin
                    w_state_nxt = ST_DECEL;
                    w_gap_nxt   = c_gap_base;
                    w_len_nxt   = c_gap_base;
                    w_cnt_nxt   = c_cnt_init;
                end
            end
            ST_DECEL: begin
                if (w_sel_rise) begin
                    // Re-press resumes spinning; counters reload on the next release
                    w_state_nxt = ST_SPIN;
                end else if (r_gap == c_gap_one) begin
                    // A step is on the output this cycle
                    if (r_cnt == c_cnt_one) begin
                        w_state_nxt = ST_SHOW;
                        w_show_nxt  = '0;
                    end else begin
                        w_gap_nxt = r_len + c_gap_inc;
                        w_len_nxt = r_len + c_gap_inc;
                        w_cnt_nxt = r_cnt - 1'b1;
                    end
                end else begin
                    w_gap_nxt = r_gap - 1'b1;
                end
            end
            ST_SHOW: begin
                if (|w_rise) begin
                    w_new_roll  = 1'b1;
                    w_sel_nxt   = first_set(w_rise);
                    w_state_nxt = ST_SPIN;
                end else if (r_show == c_show_end) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_show_nxt = r_show + 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: output logic (next values of the registered outputs)
    // ------------------------------------------------------------------
    always_comb begin
        w_load_nxt = w_new_roll;
        w_step_nxt = 1'b0;
        if (r_state == ST_SPIN && w_state_nxt == ST_SPIN) begin
            // Step train follows the held button, one cycle behind its level
            w_step_nxt = w_sel_level;
        end else if (w_state_nxt == ST_DECEL && w_gap_nxt == c_gap_one) begin
            w_step_nxt = 1'b1;
        end
        w_busy_nxt = (w_state_nxt == ST_SPIN) || (w_state_nxt == ST_DECEL);
        if (w_new_roll) begin
            w_rv_nxt = 1'b0;
        end else if (r_state == ST_DECEL && w_state_nxt == ST_SHOW) begin
            w_rv_nxt = 1'b1;
        end else begin
            w_rv_nxt = r_rv;
        end
    end

    // ------------------------------------------------------------------
    // Datapath and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_die_sel <= DIE_D4;
            r_gap     <= '0;
            r_len     <= '0;
            r_cnt     <= '0;
            r_show    <= '0;
            r_load    <= 1'b0;
            r_step    <= 1'b0;
            r_busy    <= 1'b0;
            r_rv      <= 1'b0;
        end else begin
            r_die_sel <= w_sel_nxt;
            r_gap     <= w_gap_nxt;
            r_len     <= w_len_nxt;
            r_cnt     <= w_cnt_nxt;
            r_show    <= w_show_nxt;
            r_load    <= w_load_nxt;
            r_step    <= w_step_nxt;
            r_busy    <= w_busy_nxt;
            r_rv      <= w_rv_nxt;
        end
    end

    assign bus.die_sel      = r_die_sel;
    assign bus.load         = r_load;
    assign bus.step         = r_step;
    assign bus.busy         = r_busy;
    assign bus.result_valid = r_rv;
    assign bus.state_dbg    = {1'b0, r_state};

endmodule
`default_nettype wire

// File: tb/tb_dice_roll_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dice_roll_sequencer
//  Purpose  : Directed self-checking bench for dice_roll_sequencer with
//             DEB_CYCLES=4, DECEL_BASE=2, DECEL_INC=1, DECEL_STEPS=3,
//             SHOW_CYCLES=10. Expected strobe cycles are hand-derived;
//             u counts ticks from the cycle a scenario's stimulus is applied.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dice_roll_sequencer;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    dice_roll_sequencer_if bus ();

    dice_roll_sequencer #(
        .DEB_CYCLES  (4),
        .DECEL_BASE  (2),
        .DECEL_INC   (1),
        .DECEL_STEPS (3),
        .SHOW_CYCLES (10)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Advance one clock; observe #1 after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_idle(input string tag);
        for (int k = 0; k < 200 && bus.state_dbg != 3'd0; k++) begin
            tick();
        end
        chk(tag, 32'(bus.state_dbg), 32'd0);
    endtask

    initial begin
        rst         = 1'b1;
        bus.btn_raw = 6'b000000;
        tick();
        tick();

        // Reset state
        chk("rst_state",   32'(bus.state_dbg),    32'd0);
        chk("rst_die_sel", 32'(bus.die_sel),      32'd0);
        chk("rst_load",    32'(bus.load),         32'd0);
        chk("rst_step",    32'(bus.step),         32'd0);
        chk("rst_busy",    32'(bus.busy),         32'd0);
        chk("rst_rv",      32'(bus.result_valid), 32'd0);

        // 1: d6 held 20 cycles; load@5, spin steps 6..24, decel steps 26,29,33,
        //    SHOW/result_valid @34, IDLE @44
        rst         = 1'b0;
        bus.btn_raw = 6'b000010;
        for (int u = 1; u <= 44; u++) begin
            tick();
            if (u == 20) bus.btn_raw = 6'b000000;
            chk($sformatf("t1_load@%0d", u), 32'(bus.load), 32'(u == 5));
            chk($sformatf("t1_step@%0d", u), 32'(bus.step),
                32'((u >= 6 && u <= 24) || u == 26 || u == 29 || u == 33));
            if (u == 5) begin
                chk("t1_die_sel", 32'(bus.die_sel), 32'd1);
                chk("t1_busy",    32'(bus.busy),    32'd1);
            end
            if (u == 25) chk("t1_decel_state", 32'(bus.state_dbg), 32'd2);
            if (u == 33) chk("t1_rv_before",   32'(bus.result_valid), 32'd0);
            if (u == 34) begin
                chk("t1_rv",         32'(bus.result_valid), 32'd1);
                chk("t1_show_state", 32'(bus.state_dbg),    32'd3);
                chk("t1_show_busy",  32'(bus.busy),         32'd0);
            end
            if (u == 43) chk("t1_still_show", 32'(bus.state_dbg), 32'd3);
        end
        chk("t1_idle",    32'(bus.state_dbg),    32'd0);
        chk("t1_rv_hold", 32'(bus.result_valid), 32'd1);

        // 2: d4 glitch of 3 cycles is rejected
        bus.btn_raw = 6'b000001;
        for (int u = 1; u <= 12; u++) begin
            tick();
            if (u == 3) bus.btn_raw = 6'b000000;
            chk($sformatf("t2_load@%0d", u),  32'(bus.load),      32'd0);
            chk($sformatf("t2_step@%0d", u),  32'(bus.step),      32'd0);
            chk($sformatf("t2_state@%0d", u), 32'(bus.state_dbg), 32'd0);
        end
        chk("t2_rv_hold", 32'(bus.result_valid), 32'd1);

        // 3: d8 and d20 together -> d8 wins, single load
        bus.btn_raw = 6'b010100;
        for (int u = 1; u <= 12; u++) begin
            tick();
            if (u == 8) bus.btn_raw = 6'b000000;
            chk($sformatf("t3_load@%0d", u), 32'(bus.load), 32'(u == 5));
            if (u == 5) begin
                chk("t3_die_sel", 32'(bus.die_sel),      32'd2);
                chk("t3_rv_clr",  32'(bus.result_valid), 32'd0);
            end
        end
        wait_idle("t3_wait_idle");

        // 4: d100 pressed during d10 spin is ignored
        bus.btn_raw = 6'b001000;
        for (int u = 1; u <= 30; u++) begin
            tick();
            if (u == 7)  bus.btn_raw = 6'b101000;
            if (u == 16) bus.btn_raw = 6'b000000;
            chk($sformatf("t4_load@%0d", u), 32'(bus.load), 32'(u == 5));
            chk($sformatf("t4_step@%0d", u), 32'(bus.step),
                32'((u >= 6 && u <= 20) || u == 22 || u == 25 || u == 29));
            if (u >= 5) chk($sformatf("t4_die_sel@%0d", u), 32'(bus.die_sel), 32'd3);
        end
        chk("t4_show", 32'(bus.state_dbg),    32'd3);
        chk("t4_rv",   32'(bus.result_valid), 32'd1);
        wait_idle("t4_wait_idle");

        // 5: d6 re-pressed mid-DECEL -> SPIN without load, then full DECEL
        bus.btn_raw = 6'b000010;
        for (int u = 1; u <= 38; u++) begin
            tick();
            if (u == 8)  bus.btn_raw = 6'b000000;
            if (u == 14) bus.btn_raw = 6'b000010;
            if (u == 24) bus.btn_raw = 6'b000000;
            chk($sformatf("t5_load@%0d", u), 32'(bus.load), 32'(u == 5));
            chk($sformatf("t5_step@%0d", u), 32'(bus.step),
                32'((u >= 6 && u <= 12) || u == 14 || u == 17 ||
                    (u >= 20 && u <= 28) || u == 30 || u == 33 || u == 37));
            if (u == 18) chk("t5_decel", 32'(bus.state_dbg), 32'd2);
            if (u == 19) chk("t5_respin", 32'(bus.state_dbg), 32'd1);
            if (u == 37) chk("t5_rv_before", 32'(bus.result_valid), 32'd0);
        end
        chk("t5_show", 32'(bus.state_dbg),    32'd3);
        chk("t5_rv",   32'(bus.result_valid), 32'd1);

        // 6: d20 pressed during SHOW starts a new roll; reset mid-DECEL abandons it
        bus.btn_raw = 6'b010000;
        for (int u = 1; u <= 36; u++) begin
            tick();
            if (u == 8)  bus.btn_raw = 6'b000000;
            if (u == 15) rst = 1'b1;
            if (u == 16) rst = 1'b0;
            chk($sformatf("t6_load@%0d", u), 32'(bus.load), 32'(u == 5));
            chk($sformatf("t6_step@%0d", u), 32'(bus.step),
                32'((u >= 6 && u <= 12) || u == 14));
            if (u == 4) chk("t6_in_show", 32'(bus.state_dbg), 32'd3);
            if (u == 5) chk("t6_die_sel", 32'(bus.die_sel),   32'd4);
            if (u == 15) chk("t6_decel",  32'(bus.state_dbg), 32'd2);
            if (u == 16) begin
                chk("t6_rst_die_sel", 32'(bus.die_sel),      32'd0);
                chk("t6_rst_busy",    32'(bus.busy),         32'd0);
                chk("t6_rst_rv",      32'(bus.result_valid), 32'd0);
            end
            if (u >= 16) chk($sformatf("t6_state@%0d", u), 32'(bus.state_dbg), 32'd0);
        end

        // 7: button held through reset reads as a fresh press after release
        bus.btn_raw = 6'b100000;
        rst         = 1'b1;
        for (int u = 1; u <= 8; u++) begin
            tick();
            if (u == 1) rst = 1'b0;
            chk($sformatf("t7_load@%0d", u), 32'(bus.load), 32'(u == 6));
            if (u == 6) chk("t7_die_sel", 32'(bus.die_sel), 32'd5);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
